// File: rtl/sync_xfer_arbiter_pkg.sv
// Shared state type and counter sizing helper for the sync_xfer_arbiter slice.
package sync_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } xfer_state_t;

  // One counter serves both windows, so it is sized for the longer of the two.
  function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
    int longest;
    longest = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    return (longest < 2) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/sync_xfer_arbiter_if.sv
// Requester/synchronizer bundle for sync_xfer_arbiter.
// ack_in exists only when SYNC_ACK_HANDSHAKE_EN is defined.
interface sync_xfer_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int BUS_WIDTH = 8
);
  import sync_xfer_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*BUS_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic [BUS_WIDTH-1:0]         unsync_bus;
  logic                         bus_enable;
  logic                         busy;
  logic [ID_W-1:0]              cur_id;
`ifdef SYNC_ACK_HANDSHAKE_EN
  logic                         ack_in;
`endif

  modport master (
    output req_valid,
    output req_data,
`ifdef SYNC_ACK_HANDSHAKE_EN
    output ack_in,
`endif
    input  req_ready,
    input  unsync_bus,
    input  bus_enable,
    input  busy,
    input  cur_id
  );

  modport slave (
    input  req_valid,
    input  req_data,
`ifdef SYNC_ACK_HANDSHAKE_EN
    input  ack_in,
`endif
    output req_ready,
    output unsync_bus,
    output bus_enable,
    output busy,
    output cur_id
  );

endinterface

// File: rtl/sync_xfer_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request after the pointer, wrapping.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_any
);

  logic [ID_W-1:0] cand;

  // Scan starts one past the pointer so the last winner has lowest priority.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_id    = cand;
      end
    end
  end

endmodule

// File: rtl/sync_xfer_arbiter.sv
// TX-side scheduler feeding one shared CDC word synchronizer with clean enable windows.
// Define SYNC_ACK_HANDSHAKE_EN to add ack_in and a full 4-phase handshake.
module sync_xfer_arbiter
  import sync_xfer_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int BUS_WIDTH   = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input logic                CLK,
  input logic                RST,
  sync_xfer_arbiter_if.slave bus
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [ID_W-1:0]  PTR_INIT  = ID_W'(NUM_REQ - 1);

  xfer_state_t          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [BUS_WIDTH-1:0] data_q, data_d;
  logic                 en_q, en_d;

  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_id;
  logic                 grant_any;
  logic                 ack_high_ok;
  logic                 ack_low_ok;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

`ifdef SYNC_ACK_HANDSHAKE_EN
  logic ack_meta;
  logic ack_sync;

  // ack_in comes from the destination domain, so it is double-flopped before use.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ack_meta <= 1'b0;
      ack_sync <= 1'b0;
    end else begin
      ack_meta <= bus.ack_in;
      ack_sync <= ack_meta;
    end
  end

  assign ack_high_ok = ack_sync;
  assign ack_low_ok  = ~ack_sync;
`else
  assign ack_high_ok = 1'b1;
  assign ack_low_ok  = 1'b1;
`endif

  // Ready is only offered while idle and never while reset is asserted.
  assign bus.req_ready  = ((state_q == IDLE) && !RST) ? grant : '0;
  assign bus.unsync_bus = data_q;
  assign bus.bus_enable = en_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.cur_id     = id_q;

  // Data is captured only on accept, so the bus is frozen through HOLD and GAP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    data_d  = data_q;
    en_d    = en_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
          ptr_d   = grant_id;
          id_d    = grant_id;
          data_d  = bus.req_data[int'(grant_id)*BUS_WIDTH +: BUS_WIDTH];
          en_d    = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (ack_high_ok) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
          en_d    = 1'b0;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (ack_low_ok) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= PTR_INIT;
      id_q    <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      data_q  <= data_d;
      en_q    <= en_d;
    end
  end

endmodule

// File: tb/tb_sync_xfer_arbiter.sv
// Self-checking bench for sync_xfer_arbiter: vector table, directed corners, random vs model.
// With SYNC_ACK_HANDSHAKE_EN defined only the ack handshake sequence runs.
module tb_sync_xfer_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int H = 4;
  localparam int G = 2;

  typedef struct {
    logic         rst;
    logic [N-1:0] valid;
    logic [N*W-1:0] data;
    logic [N-1:0] ready;
    logic         en;
    logic         busy;
    logic [W-1:0] bus;
    logic [1:0]   id;
  } vec_t;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  sync_xfer_arbiter_if #(.NUM_REQ(N), .BUS_WIDTH(W)) bus_if ();

  sync_xfer_arbiter #(
    .NUM_REQ     (N),
    .BUS_WIDTH   (W),
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_if)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: m_k counts edges since the last accept (0 = idle).
  int           m_k;
  int           m_ptr;
  int           m_id;
  logic [W-1:0] m_bus;

  int   grants[$];
  int   rises[$];
  logic prev_en;
  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int model_winner(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (((v >> c) & N'(1)) != '0) return c;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (((v >> i) & N'(1)) != '0) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_k = 0; m_ptr = N - 1; m_id = 0; m_bus = '0;
  endtask

  task automatic model_update();
    int w;
    if (RST) begin
      model_reset();
    end else if (m_k == 0) begin
      w = model_winner(bus_if.req_valid);
      if (w >= 0) begin
        m_k = 1; m_ptr = w; m_id = w;
        m_bus = W'(bus_if.req_data >> (w * W));
      end
    end else begin
      m_k++;
      if (m_k > H + G) m_k = 0;
    end
  endtask

  task automatic apply_stimulus(input logic rst, input logic [N-1:0] v, input logic [N*W-1:0] d);
    @(negedge CLK);
    RST              = rst;
    bus_if.req_valid = v;
    bus_if.req_data  = d;
    #1;
  endtask

  task automatic check_output();
    int           w;
    logic [N-1:0] exp_ready;
    exp_ready = '0;
    w = model_winner(bus_if.req_valid);
    if (m_k == 0 && !RST && w >= 0) exp_ready = N'(1) << w;
    check("ready",      32'(bus_if.req_ready),  32'(exp_ready));
    check("bus_enable", 32'(bus_if.bus_enable), 32'(m_k >= 1 && m_k <= H));
    check("busy",       32'(bus_if.busy),       32'(m_k >= 1));
    check("unsync_bus", 32'(bus_if.unsync_bus), 32'(m_bus));
    check("cur_id",     32'(bus_if.cur_id),     32'(m_id));
  endtask

  task automatic record();
    if (bus_if.req_ready != '0) grants.push_back(onehot_idx(bus_if.req_ready));
    if (bus_if.bus_enable && !prev_en) rises.push_back(cyc);
    prev_en = bus_if.bus_enable;
    cyc++;
  endtask

  task automatic step(input logic rst, input logic [N-1:0] v, input logic [N*W-1:0] d);
    apply_stimulus(rst, v, d);
    check_output();
    record();
    model_update();
  endtask

  function automatic logic [N*W-1:0] rand_data();
    return (N*W)'($urandom);
  endfunction

  task automatic reset_dut();
    step(1'b1, '0, '0);
    step(1'b1, '0, '0);
    grants.delete();
    rises.delete();
  endtask

  task automatic table_test();
    tbl[0] = '{1'b1, 4'b0001, 32'h0000_00A5, 4'b0000, 1'b0, 1'b0, 8'h00, 2'd0};
    tbl[1] = '{1'b0, 4'b0001, 32'h0000_00A5, 4'b0001, 1'b0, 1'b0, 8'h00, 2'd0};
    tbl[2] = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b1, 8'hA5, 2'd0};
    tbl[3] = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b1, 8'hA5, 2'd0};
    tbl[4] = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b1, 8'hA5, 2'd0};
    tbl[5] = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b1, 8'hA5, 2'd0};
    tbl[6] = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b1, 8'hA5, 2'd0};
    tbl[7] = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b1, 8'hA5, 2'd0};
    tbl[8] = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b0, 8'hA5, 2'd0};
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(tbl[i].rst, tbl[i].valid, tbl[i].data);
      check($sformatf("tbl%0d_ready", i), 32'(bus_if.req_ready),  32'(tbl[i].ready));
      check($sformatf("tbl%0d_en", i),    32'(bus_if.bus_enable), 32'(tbl[i].en));
      check($sformatf("tbl%0d_busy", i),  32'(bus_if.busy),       32'(tbl[i].busy));
      check($sformatf("tbl%0d_bus", i),   32'(bus_if.unsync_bus), 32'(tbl[i].bus));
      check($sformatf("tbl%0d_id", i),    32'(bus_if.cur_id),     32'(tbl[i].id));
      record();
      model_update();
    end
  endtask

  task automatic order_test();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    reset_dut();
    for (int i = 0; i < 35; i++) step(1'b0, 4'b1111, rand_data());
    check("order_count", 32'(grants.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < grants.size()) check($sformatf("order%0d", i), 32'(grants[i]), 32'(exp_order[i]));
    check("rise_count", 32'(rises.size()), 32'd5);
    for (int i = 1; i < 5; i++)
      if (i < rises.size()) check($sformatf("rise_gap%0d", i), 32'(rises[i] - rises[i-1]), 32'(H + G + 1));
  endtask

  task automatic skip_test();
    reset_dut();
    step(1'b0, 4'b0010, rand_data());
    for (int i = 0; i < 10; i++) step(1'b0, 4'b0110, rand_data());
    check("skip_count", 32'(grants.size()), 32'd2);
    if (grants.size() >= 2) begin
      check("skip_first",  32'(grants[0]), 32'd1);
      check("skip_second", 32'(grants[1]), 32'd2);
    end
  endtask

  task automatic reset_mid_test();
    reset_dut();
    step(1'b0, 4'b0100, rand_data());
    step(1'b0, 4'b0000, rand_data());
    step(1'b1, 4'b1111, rand_data());
    apply_stimulus(1'b0, 4'b0000, '0);
    check("rst_en",   32'(bus_if.bus_enable), 32'd0);
    check("rst_busy", 32'(bus_if.busy),       32'd0);
    check("rst_id",   32'(bus_if.cur_id),     32'd0);
    check_output();
    record();
    model_update();
    check("rst_grants", 32'(grants.size()), 32'd1);
  endtask

  task automatic pulse_test();
    reset_dut();
    step(1'b0, 4'b0001, 32'h1234_5678);
    step(1'b0, 4'b0000, rand_data());
    step(1'b0, 4'b0100, rand_data());
    for (int i = 0; i < 7; i++) step(1'b0, 4'b0000, rand_data());
    check("pulse_grants", 32'(grants.size()), 32'd1);
    check("pulse_bus",    32'(bus_if.unsync_bus), 32'h78);
  endtask

  task automatic random_test();
    logic [N-1:0] v;
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      step($urandom_range(0, 149) == 0, v, rand_data());
    end
  endtask

`ifdef SYNC_ACK_HANDSHAKE_EN
  task automatic ack_test();
    int n;
    bus_if.ack_in = 1'b0;
    reset_dut();
    apply_stimulus(1'b0, 4'b0001, 32'h0000_00A5);
    check("ack_ready", 32'(bus_if.req_ready), 32'b0001);
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(1'b0, '0, '0);
      check("ack_hold_en", 32'(bus_if.bus_enable), 32'd1);
    end
    bus_if.ack_in = 1'b1;
    n = 0;
    while (bus_if.bus_enable && n <= 10) begin
      @(posedge CLK); #1; n++;
    end
    check("ack_rise_delay", 32'(n), 32'd3);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, '0, '0);
      check("ack_gap_busy", 32'(bus_if.busy), 32'd1);
    end
    bus_if.ack_in = 1'b0;
    n = 0;
    while (bus_if.busy && n <= 10) begin
      @(posedge CLK); #1; n++;
    end
    check("ack_fall_delay", 32'(n), 32'd3);
  endtask
`endif

  initial begin
    RST              = 1'b1;
    bus_if.req_valid = '0;
    bus_if.req_data  = '0;
`ifdef SYNC_ACK_HANDSHAKE_EN
    bus_if.ack_in    = 1'b0;
`endif
    prev_en = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
`ifdef SYNC_ACK_HANDSHAKE_EN
    ack_test();
`else
    table_test();
    order_test();
    skip_test();
    reset_mid_test();
    pulse_test();
    random_test();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
